ps2_receiver: RTL
=================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: scan-code FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples required before the filtered keyboard clock changes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32000: clocks without a falling edge before a partial frame is aborted (2 ms at 16 MHz).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 CLK_16mhz  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 keyboard_clock  in  1  raw PS/2 clock from the pad, asynchronous.
REQ-008 keyboard_data  in  1  raw PS/2 data from the pad, asynchronous.
REQ-009 scan_code  out  8  FIFO head byte; valid only while scan_valid=1.
REQ-010 scan_valid  out  1  FIFO not empty.
REQ-011 scan_ready  in  1  consumer accepts the head byte when scan_valid=1.
REQ-012 overflow  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
REQ-013 frame_error  out  1  one-cycle pulse: frame aborted (bad stop, parity, or timeout).

Function
REQ-014 SHALL pass both PS/2 inputs through 2-flop synchronizers before use.
REQ-015 SHALL change the filtered clock only after FILTER_LEN consecutive equal synchronized samples; shorter glitches SHALL be ignored.
REQ-016 SHALL form a one-cycle strobe on each filtered-clock 1->0 transition and sample synchronized data in that cycle.
REQ-017 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: strobe with data=0 -> DATA, bit count 0; strobe with data=1 -> stay in IDLE, no error.
REQ-019 DATA: each strobe shifts one bit in LSB-first order; the 8th strobe -> PARITY.
REQ-020 PARITY: strobe captures the parity bit -> STOP.
REQ-021 STOP: strobe with data=1 and valid parity SHALL push the byte; otherwise frame_error pulses and the byte is discarded; -> IDLE either way.
REQ-022 Outside IDLE, the timeout counter SHALL clear on each strobe; on reaching TIMEOUT_CYCLES it SHALL return to IDLE, pulse frame_error, and discard the partial byte.
REQ-023 A pushed byte SHALL appear with scan_valid=1 in the cycle after the STOP strobe when the FIFO was empty.
REQ-024 A pop occurs on scan_valid and scan_ready in the same cycle; the next entry or scan_valid=0 SHALL follow in the next cycle.
REQ-025 Push while full without a simultaneous pop: byte dropped, overflow pulses, FIFO contents unchanged.
REQ-026 Push and pop in the same cycle while full: both SHALL succeed, no overflow.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count is clog2(FIFO_DEPTH)+1 bits wide.
REQ-028 scan_ready asserted while scan_valid=0 SHALL have no effect.

Reset
REQ-029 On reset: FSM=IDLE; counters, pointers and shift register = 0; scan_code=0x00; scan_valid, overflow and frame_error = 0.
REQ-030 On reset, synchronizer flops and the filtered clock SHALL be 1 (PS/2 idle-high), so reset release creates no strobe.
REQ-031 Reset mid-frame SHALL discard the partial frame and FIFO contents without pulsing frame_error.

Configuration
REQ-032 With PS2_PARITY_CHECK_EN defined: odd parity over data and parity bit is checked; a mismatch gives frame_error and drops the byte.
REQ-033 Without PS2_PARITY_CHECK_EN: the parity bit is sampled and ignored; only the stop bit is checked.

Verification
REQ-034 Frame 0x1C, parity 0, stop 1, scan_ready=1 -> scan_code=0x1C, scan_valid high for 1 cycle, no error pulses.
REQ-035 Frame 0xF0, parity 0 -> with EN: frame_error pulse, scan_valid stays 0; without EN: 0xF0 delivered.
REQ-036 Frame 0x5A with stop bit 0 -> frame_error pulse, nothing pushed, FSM back in IDLE.
REQ-037 scan_ready=0, frames 0x01..0x05 -> overflow pulses on 0x05; draining returns 0x01, 0x02, 0x03, 0x04, then scan_valid=0.
REQ-038 Clock stalled after 4 data bits for more than TIMEOUT_CYCLES -> frame_error pulse; a following frame 0x5A is delivered correctly.
REQ-039 3-cycle low glitch on keyboard_clock in IDLE -> no state change; reset asserted mid-frame then a clean 0x29 frame -> only 0x29 delivered.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the pad signals, decodes
// 11-bit frames and queues scan codes in a small FIFO. Define PS2_PARITY_CHECK_EN to check odd parity.
`timescale 1ns/1ps
module ps2_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 32000
) (
  input  logic       CLK_16mhz,
  input  logic       reset,
  input  logic       keyboard_clock,
  input  logic       keyboard_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic       overflow,
  output logic       frame_error
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          clk_s;
  logic          data_s;
  logic          strobe;

  state_t        state, state_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_bit, parity_next;
  logic [TW-1:0] timer, timer_next;
  logic          push_req;
  logic          error_next;
  logic          parity_ok;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          overflow_next;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Synchronizers and filter idle high so leaving reset never looks like a falling edge.
  always_ff @(posedge CLK_16mhz or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], keyboard_clock};
      data_sync <= {data_sync[0], keyboard_data};
      if (clk_s != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // The strobe fires in the cycle the filter commits a 1->0 change.
  assign strobe = filt_clk && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_reg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge CLK_16mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      timer       <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_bit  <= parity_next;
      timer       <= timer_next;
      frame_error <= error_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    parity_next  = parity_bit;
    timer_next   = timer;
    push_req     = 1'b0;
    error_next   = 1'b0;

    if (state != IDLE) begin
      if (strobe) begin
        timer_next = '0;
      end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        state_next   = IDLE;
        error_next   = 1'b1;
        timer_next   = '0;
        shift_next   = '0;
        bit_cnt_next = '0;
      end else begin
        timer_next = timer + TW'(1);
      end
    end

    if (strobe) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            shift_next   = '0;
          end
        end
        DATA: begin
          shift_next   = {data_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          parity_next = data_s;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_s && parity_ok) push_req = 1'b1;
          else error_next = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign full          = (count == CW'(FIFO_DEPTH));
  assign scan_valid    = (count != '0);
  assign pop           = scan_valid && scan_ready;
  assign do_push       = push_req && (!full || pop);
  assign overflow_next = push_req && full && !pop;
  assign scan_code     = scan_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge CLK_16mhz) begin
    if (do_push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge CLK_16mhz or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow_next;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
